// File: rtl/ldpc_codeword_serializer.sv
// ldpc_codeword_serializer
// Captures one full QC-LDPC codeword (TOTAL_BLKS blocks of Z bits) in a single
// accepting cycle and streams it out LSB-first as W-bit words over a
// valid/ready/last interface. The final word is zero padded when W does not
// divide the codeword length. A new codeword may be accepted on the same edge
// as the last word of the previous one, giving gapless back-to-back frames.
// Optional build macro LDPC_SER_STATS_EN adds a completed-frame counter
// (frame_cnt) and a sticky wrap flag (ovf_sticky).
module ldpc_codeword_serializer #(
   parameter int Z          = 54,
   parameter int TOTAL_BLKS = 24,
   parameter int W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cw_valid,
   output logic              cw_ready,
   input  logic [Z-1:0]      codeword [TOTAL_BLKS-1:0],
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
`ifdef LDPC_SER_STATS_EN
   ,
   output logic [15:0]       frame_cnt,
   output logic [0:0]        ovf_sticky
`endif
);

   localparam int N         = Z * TOTAL_BLKS;
   localparam int NUM_WORDS = (N + W - 1) / W;
   localparam int PAD_W     = NUM_WORDS * W;
   localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

   generate
      if (W < 1 || W > N) begin : g_bad_w
         $error("ldpc_codeword_serializer: W must satisfy 1 <= W <= Z*TOTAL_BLKS");
      end
   endgenerate

   typedef enum logic {IDLE, SEND} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [N-1:0]     stream;
   logic [PAD_W-1:0] data_reg;
   logic             accept;

   // Flatten the block array into stream order: block 0 bit 0 lands at stream bit 0.
   always_comb begin
      stream = '0;
      for (int b = 0; b < TOTAL_BLKS; b++) begin
         stream[b*Z +: Z] = codeword[b];
      end
   end

   // Codeword capture; padding bits above N stay zero so the last word is zero filled.
   always_ff @(posedge clk) begin
      if (accept) begin
         data_reg <= PAD_W'(stream);
      end
   end

   // State and word counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state, handshake and output decode; data is forced to zero outside SEND.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      cw_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      out_data   = '0;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            cw_ready = 1'b1;
            if (cw_valid) begin
               accept     = 1'b1;
               state_next = SEND;
               cnt_next   = '0;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            out_last  = (cnt == LAST_IDX);
            out_data  = data_reg[int'(cnt)*W +: W];
            if (out_ready) begin
               if (cnt != LAST_IDX) begin
                  cnt_next = cnt + 1'b1;
               end else begin
                  // Last word leaves this cycle: hand off straight to the next codeword if offered.
                  cw_ready = 1'b1;
                  cnt_next = '0;
                  if (cw_valid) begin
                     accept     = 1'b1;
                     state_next = SEND;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef LDPC_SER_STATS_EN
   // Completed-frame counter with a sticky flag recording any wrap past 16'hFFFF.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt  <= '0;
         ovf_sticky <= '0;
      end else if (out_valid && out_ready && out_last) begin
         frame_cnt <= frame_cnt + 16'd1;
         if (frame_cnt == 16'hFFFF) begin
            ovf_sticky <= 1'b1;
         end
      end
   end
`endif

endmodule
